xrisc_muldiv: RTL
=================

Name: xrisc_muldiv

Overview:
- Iterative multiply/divide unit implementing the full RV32M set (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU).
- Sits beside the ALU in the execute stage and is fed from the same SrcA/SrcB operand path.
- The core stalls PC and register-file writeback while `busy` is high, then writes `result` when `done` pulses.
- Replaces the combinational `*` and `/` paths, moving the long arithmetic off the single-cycle critical path.

Parameters:
- XLEN, 32, operand and result width. Only 32 is supported and verified.
- CNT_W, 6, iteration counter width. Must satisfy 2^CNT_W > XLEN.

Ports:
- clk, input, 1, core clock; all state updates on the rising edge.
- reset, input, 1, synchronous active-high reset.
- start, input, 1, request to begin an operation; sampled only in IDLE.
- funct3, input, 3, M-extension op select: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- srca, input, 32, rs1 operand; multiplicand or dividend.
- srcb, input, 32, rs2 operand; multiplier or divisor.
- kill, input, 1, abort the in-flight operation (pipeline flush).
- busy, output, 1, high while an operation is in flight; the core holds PC and suppresses RegWrite.
- done, output, 1, single-cycle pulse; `result` is valid in this cycle.
- result, output, 32, final result; held stable until the next completion.

Behaviour:
- Reset (synchronous, active-high): state=IDLE, busy=0, done=0, result=0, and all internal registers cleared. Reset has priority over `kill` and `start` and applies mid-operation with no `done`.
- States:
  - IDLE: waiting for `start`.
  - CALC: 32 iterations.
  - SIGN: sign correction and select of the result half.
  - DONE: `done=1`, result valid.
- `busy` = state is CALC or SIGN. `done` = state is DONE.
- IDLE -> CALC on `start` (not `kill`) with a normal op. `srca`, `srcb` and `funct3` are latched at that edge; later input changes have no effect.
- Latency, start sampled at edge of cycle N:
  - CALC in cycles N+1..N+32.
  - SIGN in cycle N+33.
  - DONE in cycle N+34.
  - Back to IDLE at N+35.
- Fast path: IDLE -> DONE directly, `done` in cycle N+1, busy never asserted, for:
  - Divisor zero: DIV/DIVU give 0xFFFFFFFF; REM/REMU give the dividend.
  - Signed overflow (DIV/REM with srca=0x80000000, srcb=0xFFFFFFFF): DIV gives 0x80000000; REM gives 0.
- Multiply:
  - Operands are converted to magnitudes per signedness. MULHSU treats rs1 as signed and rs2 as unsigned.
  - Radix-2 shift-add into a 64-bit product: one partial product per CALC cycle, LSB first.
  - SIGN negates the 64-bit product if the operand signs differ.
  - MUL selects the low word; MULH, MULHSU and MULHU select the high word.
- Divide:
  - Restoring division on magnitudes: one quotient bit per CALC cycle, MSB first.
  - SIGN applies the quotient sign as sign(a) XOR sign(b).
  - The remainder takes the sign of the dividend (RISC-V truncating semantics).
- Iteration counter: loads 31 on entry to CALC and decrements. CALC -> SIGN when the counter is 0 at the edge. No wrap occurs.
- `start` while busy or in DONE is ignored: not queued, no effect on the in-flight op.
- `start` in the DONE cycle is ignored. The core re-issues from IDLE at N+35 or later.
- `kill`:
  - In CALC or SIGN: next state IDLE, `done` never asserts, `result` keeps its previous value.
  - In DONE: no effect; the pulse still completes.
  - With `start` in IDLE: kill wins and the op is not accepted.
- `result` updates only on the edge entering DONE; otherwise it holds.

Decomposition:
- Shared package `xrisc_pkg`:
  - `mdu_op_e` enum of the eight funct3 encodings.
  - `mdu_state_e` (IDLE, CALC, SIGN, DONE).
  - Constants MDU_ITERS=32 and OP_M_FUNCT7=7'b0000001 for the decoder's M-extension detection.
- One sub-module is natural: `xrisc_sign_fix`, combinational magnitude conversion/negation with 64-bit result select, used on entry to CALC and in SIGN.
- The iteration datapath stays in the top block.

Test Plan:
- MUL: srca=7, srcb=0xFFFFFFFD, start at N -> busy N+1..N+33, done only at N+34, result=0xFFFFFFEB. MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE. MULH same operands -> 0x00000000.
- DIV and REM: DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD. REM same operands -> 0xFFFFFFFF. DIVU 0xFFFFFFF9 / 2 -> 0x7FFFFFFC. Each completes at N+34.
- Divisor zero: DIV 5/0 -> 0xFFFFFFFF with done at N+1 and busy never high. REMU 5%0 -> 5.
- Overflow: DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000. REM same operands -> 0. Both at N+1.
- Ignored start and operand latching: start again at N+5 with different operands -> ignored, first result returned at N+34. Operands changed at N+1 -> no effect on the result.
- Kill and reset: kill at N+10 -> IDLE at N+11, no done, result unchanged. Reset at N+20 -> IDLE at N+21, result=0, no done. A new start afterwards completes normally.

Source files
------------

// File: rtl/xrisc_pkg.sv
// Shared definitions for the XRISC core: M-extension op encodings, multiply/divide
// unit state encoding and related constants.
package xrisc_pkg;

    // funct3 encodings of the RV32M instructions
    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } mdu_op_e;

    // Multiply/divide unit sequencing states
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CALC,
        ST_SIGN,
        ST_DONE
    } mdu_state_e;

    // Number of CALC iterations (one bit per cycle)
    localparam int MDU_ITERS = 32;

    // funct7 value the decoder uses to recognise M-extension instructions
    localparam logic [6:0] OP_M_FUNCT7 = 7'b0000001;

    // Divide-family ops (DIV, DIVU, REM, REMU)
    function automatic logic is_div_op(input mdu_op_e op);
        return op[2];
    endfunction

    // Remainder ops (REM, REMU)
    function automatic logic is_rem_op(input mdu_op_e op);
        return op[2] & op[1];
    endfunction

endpackage

// File: rtl/xrisc_sign_fix.sv
// Combinational sign handling for the multiply/divide unit: converts operands to
// magnitudes on entry to CALC, and in SIGN applies the result sign and selects
// the result word from the {hi, lo} working pair.
module xrisc_sign_fix
    import xrisc_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  mdu_op_e          op,
    input  logic [XLEN-1:0]  srca,
    input  logic [XLEN-1:0]  srcb,
    input  logic [XLEN-1:0]  hi,
    input  logic [XLEN-1:0]  lo,
    input  logic             neg_res,
    input  logic             neg_rem,
    output logic [XLEN-1:0]  mag_a,
    output logic [XLEN-1:0]  mag_b,
    output logic             sign_res,
    output logic             sign_rem,
    output logic [XLEN-1:0]  result
);

    logic            a_signed;
    logic            b_signed;
    logic            neg_a;
    logic            neg_b;
    logic [2*XLEN-1:0] wide;

    // Operand magnitudes/signs, then sign correction and word select of the result
    always_comb begin
        // NOTE: every signal driven here gets a value on every path, otherwise a latch is inferred.
        a_signed = 1'b0;
        b_signed = 1'b0;
        result   = '0;
        wide     = {hi, lo};

        // MULHSU: rs1 signed, rs2 unsigned; MUL low word is sign-agnostic
        case (op)
            OP_MUL, OP_MULH, OP_DIV, OP_REM: begin
                a_signed = 1'b1;
                b_signed = 1'b1;
            end
            OP_MULHSU: a_signed = 1'b1;
            default: ;
        endcase

        neg_a    = a_signed & srca[XLEN-1];
        neg_b    = b_signed & srcb[XLEN-1];
        mag_a    = neg_a ? -srca : srca;
        mag_b    = neg_b ? -srcb : srcb;
        sign_res = neg_a ^ neg_b;
        // Remainder follows the dividend sign (truncating division)
        sign_rem = neg_a;

        if (neg_res) begin
            wide = -{hi, lo};
        end

        // Divide keeps the quotient in lo and the remainder in hi
        case (op)
            OP_MUL:                         result = wide[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU:   result = wide[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:                result = neg_res ? -lo : lo;
            OP_REM, OP_REMU:                result = neg_rem ? -hi : hi;
            default:                        result = '0;
        endcase
    end

endmodule

// File: rtl/xrisc_muldiv.sv
// Iterative RV32M multiply/divide unit. Radix-2 shift-add multiply (LSB first)
// and restoring divide (MSB first) on operand magnitudes, followed by a single
// sign-correction cycle. Divide-by-zero and signed overflow complete directly
// from IDLE without entering CALC.
module xrisc_muldiv
    import xrisc_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       funct3,
    input  logic [XLEN-1:0]  srca,
    input  logic [XLEN-1:0]  srcb,
    input  logic             kill,
    output logic             busy,
    output logic             done,
    output logic [XLEN-1:0]  result
);

    localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

    mdu_state_e        state;
    mdu_op_e           op_q;
    logic [CNT_W-1:0]  cnt;
    // Multiply: hi = accumulator, lo = remaining multiplier bits, dreg = multiplicand.
    // Divide:   hi = partial remainder, lo = dividend shifting out / quotient shifting in, dreg = divisor.
    logic [XLEN-1:0]   hi;
    logic [XLEN-1:0]   lo;
    logic [XLEN-1:0]   dreg;
    logic              neg_res_q;
    logic              neg_rem_q;

    mdu_op_e           op_in;
    mdu_op_e           op_sel;
    logic [XLEN-1:0]   mag_a;
    logic [XLEN-1:0]   mag_b;
    logic              sign_res;
    logic              sign_rem;
    logic [XLEN-1:0]   fix_res;

    logic              div_zero;
    logic              div_ovf;
    logic [XLEN-1:0]   fast_res;

    logic [XLEN:0]     mul_sum;
    logic [XLEN:0]     div_shift;
    logic              div_ge;
    logic [XLEN-1:0]   div_diff;
    logic [XLEN-1:0]   hi_next;
    logic [XLEN-1:0]   lo_next;

    assign op_in  = mdu_op_e'(funct3);
    // Operand conversion uses the incoming op; sign correction uses the latched op
    assign op_sel = (state == ST_IDLE) ? op_in : op_q;

    xrisc_sign_fix #(
        .XLEN (XLEN)
    ) u_sign_fix (
        .op       (op_sel),
        .srca     (srca),
        .srcb     (srcb),
        .hi       (hi),
        .lo       (lo),
        .neg_res  (neg_res_q),
        .neg_rem  (neg_rem_q),
        .mag_a    (mag_a),
        .mag_b    (mag_b),
        .sign_res (sign_res),
        .sign_rem (sign_rem),
        .result   (fix_res)
    );

    // Fast-path detection and result for divide-by-zero and signed overflow
    always_comb begin
        div_zero = is_div_op(op_in) && (srcb == '0);
        div_ovf  = ((op_in == OP_DIV) || (op_in == OP_REM)) &&
                   (srca == INT_MIN) && (srcb == '1);
        fast_res = '0;
        if (div_zero) begin
            fast_res = is_rem_op(op_in) ? srca : '1;
        end else if (div_ovf) begin
            fast_res = is_rem_op(op_in) ? '0 : INT_MIN;
        end
    end

    // One iteration step of the shift-add multiply or restoring divide
    always_comb begin
        // Multiply: add multiplicand when the current multiplier bit is set, then
        // shift the {carry, hi, lo} pair right by one.
        mul_sum   = {1'b0, hi} + (lo[0] ? {1'b0, dreg} : '0);
        // Divide: shift next dividend bit into the remainder and trial-subtract.
        // The remainder stays below the divisor, so the shifted value fits XLEN+1 bits
        // and a successful difference fits XLEN bits.
        div_shift = {hi, lo[XLEN-1]};
        div_ge    = (div_shift >= {1'b0, dreg});
        div_diff  = div_shift[XLEN-1:0] - dreg;

        if (is_div_op(op_q)) begin
            hi_next = div_ge ? div_diff : div_shift[XLEN-1:0];
            lo_next = {lo[XLEN-2:0], div_ge};
        end else begin
            hi_next = mul_sum[XLEN:1];
            lo_next = {mul_sum[0], lo[XLEN-1:1]};
        end
    end

    // Control FSM and datapath registers, with registered busy/done outputs
    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every register sees pre-edge values.
        if (reset) begin
            state     <= ST_IDLE;
            op_q      <= OP_MUL;
            cnt       <= '0;
            hi        <= '0;
            lo        <= '0;
            dreg      <= '0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            result    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    busy <= 1'b0;
                    done <= 1'b0;
                    if (start && !kill) begin
                        if (div_zero || div_ovf) begin
                            result <= fast_res;
                            done   <= 1'b1;
                            state  <= ST_DONE;
                        end else begin
                            op_q      <= op_in;
                            hi        <= '0;
                            lo        <= is_div_op(op_in) ? mag_a : mag_b;
                            dreg      <= is_div_op(op_in) ? mag_b : mag_a;
                            neg_res_q <= sign_res;
                            neg_rem_q <= sign_rem;
                            cnt       <= CNT_W'(MDU_ITERS - 1);
                            busy      <= 1'b1;
                            state     <= ST_CALC;
                        end
                    end
                end

                ST_CALC: begin
                    if (kill) begin
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end else begin
                        hi <= hi_next;
                        lo <= lo_next;
                        if (cnt == '0) begin
                            state <= ST_SIGN;
                        end else begin
                            cnt <= cnt - CNT_W'(1);
                        end
                    end
                end

                ST_SIGN: begin
                    busy <= 1'b0;
                    if (kill) begin
                        state <= ST_IDLE;
                    end else begin
                        result <= fix_res;
                        done   <= 1'b1;
                        state  <= ST_DONE;
                    end
                end

                ST_DONE: begin
                    done  <= 1'b0;
                    state <= ST_IDLE;
                end

                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
